// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit
// Purpose  : Multi-cycle MIPS control FSM. Sequences each instruction through
//            fetch / decode / execute / memory / writeback states, stalls on
//            the memory ready handshake, drives the datapath mux selects and
//            write strobes, and counts retired instructions.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   1      rising-edge clock
//   rst            in   1      synchronous active-high reset
//   instr_op       in   6      opcode field from instruction register
//   mem_ready      in   1      memory completes current read/write this cycle
//   pc_write .. alu_src_a out 1 each   datapath write strobes / mux selects
//   alu_src_b      out  2      00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   alu_op         out  2      00 add, 01 sub, 10 funct-decoded
//   pc_source      out  2      00 ALU result, 01 ALUOut, 10 jump target
//   state          out  4      current state encoding (debug)
//   retire         out  1      last cycle of an instruction
//   illegal_op     out  1      one-cycle flag after an unknown opcode decode
//   instr_count    out  CNT_W  retired instruction count (wraps)
// ============================================================================
module mc_control_unit #(
  parameter int          CNT_W    = 16,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_ADDI  = 6'b001000,
  parameter logic [5:0]  OP_J     = 6'b000010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       instr_op,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             retire,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] count_q;
  logic             illegal_q;
  logic             illegal_d;

  // Ungated control values decoded from the current state.
  logic       pc_write_d, pc_write_cond_d, i_or_d_d, ir_write_d;
  logic       mem_read_d, mem_write_d, mem_to_reg_d, reg_dst_d;
  logic       reg_write_d, alu_src_a_d, retire_d;
  logic [1:0] alu_src_b_d, alu_op_d, pc_source_d;

  // --------------------------------------------------------------------------
  // State, counter and illegal-opcode flag registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_FETCH;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      illegal_q <= illegal_d;
      if (retire_d) begin
        count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    nxt_state       = cur_state;
    illegal_d       = 1'b0;
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    i_or_d_d        = 1'b0;
    ir_write_d      = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_to_reg_d    = 1'b0;
    reg_dst_d       = 1'b0;
    reg_write_d     = 1'b0;
    alu_src_a_d     = 1'b0;
    retire_d        = 1'b0;
    alu_src_b_d     = 2'b00;
    alu_op_d        = 2'b00;
    pc_source_d     = 2'b00;

    case (cur_state)
      S_FETCH: begin
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
        // IR load and PC+4 only on the cycle the fetch actually completes.
        ir_write_d  = mem_ready;
        pc_write_d  = mem_ready;
        if (mem_ready) nxt_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_d = 2'b11;
        // Opcodes are parameters, so an if-chain is used instead of a case.
        if ((instr_op == OP_LW) || (instr_op == OP_SW)) nxt_state = S_MEM_ADDR;
        else if (instr_op == OP_RTYPE)                  nxt_state = S_R_EXEC;
        else if (instr_op == OP_BEQ)                    nxt_state = S_BRANCH;
        else if (instr_op == OP_J)                      nxt_state = S_JUMP;
        else if (instr_op == OP_ADDI)                   nxt_state = S_ADDI_EXEC;
        else begin
          nxt_state = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        nxt_state   = (instr_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read_d = 1'b1;
        i_or_d_d   = 1'b1;
        if (mem_ready) nxt_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
        retire_d     = 1'b1;
        nxt_state    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_d = 1'b1;
        i_or_d_d    = 1'b1;
        retire_d    = mem_ready;
        if (mem_ready) nxt_state = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = 2'b10;
        nxt_state   = S_R_WB;
      end
      S_R_WB: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
        retire_d    = 1'b1;
        nxt_state   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_d     = 1'b1;
        alu_op_d        = 2'b01;
        pc_write_cond_d = 1'b1;
        pc_source_d     = 2'b01;
        retire_d        = 1'b1;
        nxt_state       = S_FETCH;
      end
      S_JUMP: begin
        pc_write_d  = 1'b1;
        pc_source_d = 2'b10;
        retire_d    = 1'b1;
        nxt_state   = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        nxt_state   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_d = 1'b1;
        retire_d    = 1'b1;
        nxt_state   = S_FETCH;
      end
      // Encodings 12-15: all outputs stay 0, recover to FETCH.
      default: nxt_state = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs are held at 0 for the whole reset cycle, so no strobe can fire
  // while an aborted instruction is still sitting in the state register.
  // --------------------------------------------------------------------------
  assign pc_write      = ~rst & pc_write_d;
  assign pc_write_cond = ~rst & pc_write_cond_d;
  assign i_or_d        = ~rst & i_or_d_d;
  assign ir_write      = ~rst & ir_write_d;
  assign mem_read      = ~rst & mem_read_d;
  assign mem_write     = ~rst & mem_write_d;
  assign mem_to_reg    = ~rst & mem_to_reg_d;
  assign reg_dst       = ~rst & reg_dst_d;
  assign reg_write     = ~rst & reg_write_d;
  assign alu_src_a     = ~rst & alu_src_a_d;
  assign retire        = ~rst & retire_d;
  assign alu_src_b     = rst ? 2'b00 : alu_src_b_d;
  assign alu_op        = rst ? 2'b00 : alu_op_d;
  assign pc_source     = rst ? 2'b00 : pc_source_d;
  assign state         = rst ? 4'd0  : cur_state;
  assign illegal_op    = ~rst & illegal_q;
  assign instr_count   = rst ? '0    : count_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_unit
// Purpose  : Directed self-checking bench for mc_control_unit. Each step
//            drives rst/mem_ready/instr_op, then compares state, the full
//            control bundle, instr_count and illegal_op against hand-written
//            expected values. The counter is built 4 bits wide so wraparound
//            is reachable in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] instr_op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, retire, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [3:0] instr_count;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  // Control bundle: {pc_write, pc_write_cond, i_or_d, ir_write, mem_read,
  //   mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
  //   alu_src_b[1:0], alu_op[1:0], pc_source[1:0], retire}
  localparam logic [16:0] C_ZERO   = 17'b0000000000_00_00_00_0;
  localparam logic [16:0] C_FET_R  = 17'b1001100000_01_00_00_0;
  localparam logic [16:0] C_FET_N  = 17'b0000100000_01_00_00_0;
  localparam logic [16:0] C_DEC    = 17'b0000000000_11_00_00_0;
  localparam logic [16:0] C_MADDR  = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] C_MRD    = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] C_MWB    = 17'b0000001010_00_00_00_1;
  localparam logic [16:0] C_MWR_R  = 17'b0010010000_00_00_00_1;
  localparam logic [16:0] C_MWR_N  = 17'b0010010000_00_00_00_0;
  localparam logic [16:0] C_REX    = 17'b0000000001_00_10_00_0;
  localparam logic [16:0] C_RWB    = 17'b0000000110_00_00_00_1;
  localparam logic [16:0] C_BR     = 17'b0100000001_00_01_01_1;
  localparam logic [16:0] C_JMP    = 17'b1000000000_00_00_10_1;
  localparam logic [16:0] C_AEX    = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] C_AWB    = 17'b0000000010_00_00_00_1;

  logic [16:0] ctl;
  assign ctl = {pc_write, pc_write_cond, i_or_d, ir_write, mem_read,
                mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_source, retire};

  mc_control_unit #(.CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_op      (instr_op),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .retire        (retire),
    .illegal_op    (illegal_op),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  // Drive inputs just after a falling edge, compare 1 ns later (well away
  // from the rising edge), then advance to the next falling edge.
  task automatic step(input string tag, input logic r, input logic rdy,
                      input logic [5:0] op, input logic [3:0] exp_st,
                      input logic [16:0] exp_ctl, input logic [3:0] exp_cnt,
                      input logic exp_ill);
    rst = r; mem_ready = rdy; instr_op = op;
    #1;
    total++;
    assert (state === exp_st) else begin
      bad++;
      $error("FAIL %s state: got %0d want %0d", tag, state, exp_st);
    end
    total++;
    assert (ctl === exp_ctl) else begin
      bad++;
      $error("FAIL %s ctl: got %b want %b", tag, ctl, exp_ctl);
    end
    total++;
    assert (instr_count === exp_cnt) else begin
      bad++;
      $error("FAIL %s count: got %0d want %0d", tag, instr_count, exp_cnt);
    end
    total++;
    assert (illegal_op === exp_ill) else begin
      bad++;
      $error("FAIL %s illegal: got %b want %b", tag, illegal_op, exp_ill);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; instr_op = RT;
    @(negedge clk);
    // Held in reset: everything forced to zero even with mem_ready high.
    step("rst_hold", 1'b1, 1'b1, RT, 4'd0, C_ZERO, 4'd0, 1'b0);

    // R-type, mem_ready high: 0,1,6,7 then FETCH with count 1.
    step("rt_fetch",  1'b0, 1'b1, RT, 4'd0, C_FET_R, 4'd0, 1'b0);
    step("rt_decode", 1'b0, 1'b1, RT, 4'd1, C_DEC,   4'd0, 1'b0);
    step("rt_exec",   1'b0, 1'b1, RT, 4'd6, C_REX,   4'd0, 1'b0);
    step("rt_wb",     1'b0, 1'b1, RT, 4'd7, C_RWB,   4'd0, 1'b0);

    // LW: 2 stall cycles in FETCH, 3 in MEM_RD -> 10 cycles.
    step("lw_fetch_s0", 1'b0, 1'b0, LW, 4'd0, C_FET_N, 4'd1, 1'b0);
    step("lw_fetch_s1", 1'b0, 1'b0, LW, 4'd0, C_FET_N, 4'd1, 1'b0);
    step("lw_fetch",    1'b0, 1'b1, LW, 4'd0, C_FET_R, 4'd1, 1'b0);
    step("lw_decode",   1'b0, 1'b0, LW, 4'd1, C_DEC,   4'd1, 1'b0);
    step("lw_addr",     1'b0, 1'b1, LW, 4'd2, C_MADDR, 4'd1, 1'b0);
    step("lw_rd_s0",    1'b0, 1'b0, LW, 4'd3, C_MRD,   4'd1, 1'b0);
    step("lw_rd_s1",    1'b0, 1'b0, LW, 4'd3, C_MRD,   4'd1, 1'b0);
    step("lw_rd_s2",    1'b0, 1'b0, LW, 4'd3, C_MRD,   4'd1, 1'b0);
    step("lw_rd",       1'b0, 1'b1, LW, 4'd3, C_MRD,   4'd1, 1'b0);
    step("lw_wb",       1'b0, 1'b1, LW, 4'd4, C_MWB,   4'd1, 1'b0);

    // SW with one write stall: no retire until mem_ready.
    step("sw_fetch",  1'b0, 1'b1, SW, 4'd0, C_FET_R, 4'd2, 1'b0);
    step("sw_decode", 1'b0, 1'b1, SW, 4'd1, C_DEC,   4'd2, 1'b0);
    step("sw_addr",   1'b0, 1'b1, SW, 4'd2, C_MADDR, 4'd2, 1'b0);
    step("sw_wr_s0",  1'b0, 1'b0, SW, 4'd5, C_MWR_N, 4'd2, 1'b0);
    step("sw_wr",     1'b0, 1'b1, SW, 4'd5, C_MWR_R, 4'd2, 1'b0);

    // ADDI
    step("addi_fetch",  1'b0, 1'b1, ADDI, 4'd0,  C_FET_R, 4'd3, 1'b0);
    step("addi_decode", 1'b0, 1'b1, ADDI, 4'd1,  C_DEC,   4'd3, 1'b0);
    step("addi_exec",   1'b0, 1'b1, ADDI, 4'd10, C_AEX,   4'd3, 1'b0);
    step("addi_wb",     1'b0, 1'b1, ADDI, 4'd11, C_AWB,   4'd3, 1'b0);

    // BEQ then J
    step("beq_fetch",  1'b0, 1'b1, BEQ, 4'd0, C_FET_R, 4'd4, 1'b0);
    step("beq_decode", 1'b0, 1'b1, BEQ, 4'd1, C_DEC,   4'd4, 1'b0);
    step("beq_branch", 1'b0, 1'b1, BEQ, 4'd8, C_BR,    4'd4, 1'b0);
    step("j_fetch",    1'b0, 1'b1, JMP, 4'd0, C_FET_R, 4'd5, 1'b0);
    step("j_decode",   1'b0, 1'b1, JMP, 4'd1, C_DEC,   4'd5, 1'b0);
    step("j_jump",     1'b0, 1'b1, JMP, 4'd9, C_JMP,   4'd5, 1'b0);

    // Illegal opcode: back to FETCH, flag high one cycle, no retire.
    step("ill_fetch",  1'b0, 1'b1, BAD, 4'd0, C_FET_R, 4'd6, 1'b0);
    step("ill_decode", 1'b0, 1'b1, BAD, 4'd1, C_DEC,   4'd6, 1'b0);
    step("ill_flag",   1'b0, 1'b0, BAD, 4'd0, C_FET_N, 4'd6, 1'b1);
    step("ill_clear",  1'b0, 1'b0, BAD, 4'd0, C_FET_N, 4'd6, 1'b0);

    // SW stalled in MEM_WR, then reset on the same edge mem_ready rises:
    // reset wins over retire, instruction aborts, count clears.
    step("rs_fetch",  1'b0, 1'b1, SW, 4'd0, C_FET_R, 4'd6, 1'b0);
    step("rs_decode", 1'b0, 1'b1, SW, 4'd1, C_DEC,   4'd6, 1'b0);
    step("rs_addr",   1'b0, 1'b1, SW, 4'd2, C_MADDR, 4'd6, 1'b0);
    step("rs_wr_s0",  1'b0, 1'b0, SW, 4'd5, C_MWR_N, 4'd6, 1'b0);
    step("rs_rst",    1'b1, 1'b1, SW, 4'd0, C_ZERO,  4'd0, 1'b0);
    step("rs_after",  1'b0, 1'b0, SW, 4'd0, C_FET_N, 4'd0, 1'b0);

    // 16 jumps on a 4-bit counter: count walks 0..15 and wraps to 0.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] c;
      c = 4'(i);
      step("wrap_fetch",  1'b0, 1'b1, JMP, 4'd0, C_FET_R, c, 1'b0);
      step("wrap_decode", 1'b0, 1'b1, JMP, 4'd1, C_DEC,   c, 1'b0);
      step("wrap_jump",   1'b0, 1'b1, JMP, 4'd9, C_JMP,   c, 1'b0);
    end
    step("wrap_end", 1'b0, 1'b0, JMP, 4'd0, C_FET_N, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle MIPS control FSM, the successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and stalls on a memory ready handshake. It drives the datapath mux selects and write strobes of the multi-cycle datapath, and counts retired instructions. Opcode encodings are parameters, so the decode set can be retargeted without touching the FSM.

## Interface
- CNT_W, 16: width of retired-instruction counter
- OP_RTYPE, 6'b000000: R-type opcode
- OP_LW, 6'b100011: load word
- OP_SW, 6'b101011: store word
- OP_BEQ, 6'b000100: branch equal
- OP_ADDI, 6'b001000: add immediate
- OP_J, 6'b000010: jump

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- instr_op  in  6  opcode field from instruction register
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls
- alu_src_b  out  2  ALU B select: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- state  out  4  current state encoding (debug)
- retire  out  1  last cycle of an instruction
- illegal_op  out  1  one-cycle flag: unknown opcode was decoded
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Moore FSM. Outputs decode from `state` only, except the mem_ready-qualified strobes. Every output not listed for a state is 0.
- States and their outputs:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready. Holds until mem_ready=1, then goes to DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00. Next state by instr_op:
    - LW, SW: MEM_ADDR
    - RTYPE: R_EXEC
    - BEQ: BRANCH
    - J: JUMP
    - ADDI: ADDI_EXEC
    - other: FETCH, and illegal_op=1 in the following cycle
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for LW, else MEM_WR.
  - MEM_RD(3): mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
  - MEM_WB(4): reg_dst=0, mem_to_reg=1, reg_write=1, retire=1. Goes to FETCH.
  - MEM_WR(5): mem_write=1, i_or_d=1, retire=mem_ready. Holds until mem_ready, then goes to FETCH.
  - R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
  - R_WB(7): reg_dst=1, mem_to_reg=0, reg_write=1, retire=1. Goes to FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, retire=1. Goes to FETCH.
  - JUMP(9): pc_write=1, pc_source=10, retire=1. Goes to FETCH.
  - ADDI_EXEC(10): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
  - ADDI_WB(11): reg_dst=0, mem_to_reg=0, reg_write=1, retire=1. Goes to FETCH.
- Encodings 12-15 are unreachable. If entered, the FSM goes to FETCH next cycle with all outputs 0.
- instr_count increments on every clock edge where retire=1. All-ones wraps to 0. An illegal opcode does not retire.
- illegal_op is registered: high for exactly the first FETCH cycle after the offending DECODE.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR. instr_op is sampled only in DECODE and MEM_ADDR.

## Timing
- Reset: on the edge with rst=1, state=FETCH, instr_count=0 and illegal_op=0.
  - While rst=1, every output is forced to 0, including mem_read and mem_write.
  - The first cycle after rst falls is FETCH.
- Reset mid-instruction (including during a memory stall) aborts the instruction with no retire. No further write strobe is issued.
- Cycle counts with mem_ready tied high: BEQ/J 3, R-type/ADDI/SW 4, LW 5. Each low cycle of mem_ready in FETCH, MEM_RD or MEM_WR adds one stall cycle.
- During a stall, all outputs hold their state values. ir_write, pc_write and the SW retire stay 0 until mem_ready=1.
- If retire and rst are both high on the same edge, the reset wins and instr_count=0.

## Test plan
- Reset, then R-type with mem_ready=1 → states 0,1,6,7,0. reg_write=1, reg_dst=1 in R_WB. instr_count=1 after 4 cycles.
- LW with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD → 10 total cycles. ir_write is a single pulse. reg_write and mem_to_reg are high only in MEM_WB.
- SW → mem_write=1 only in MEM_WR, and reg_write is never high. ADDI → alu_src_b=10 in ADDI_EXEC, and reg_write=1 with reg_dst=0.
- BEQ then J → pc_write_cond=1 with pc_source=01 in BRANCH. pc_write=1 with pc_source=10 in JUMP. instr_count=2.
- Opcode 6'b111111 → DECODE goes to FETCH. illegal_op is high for one cycle and instr_count is unchanged.
- Assert rst during MEM_WR stall → next cycle state=0, mem_write=0, count=0. With CNT_W=4 and 16 retirements → count wraps to 0.
